// File: rtl/rlc_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit control registers to the coder core.
// Independent write and read FSMs; byte-lane strobes honoured on every write.
module rlc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      reg_wr_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  function automatic logic [DW-1:0] f_merge_lanes(
    input logic [DW-1:0]     old_val,
    input logic [DW-1:0]     new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DW-1:0] res;
    res = old_val;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
      else         res[8*k +: 8] = old_val[8*k +: 8];
    end
    return res;
  endfunction

  logic [DW-1:0]     r_reg [0:3];
  w_state_t          r_w_state;
  w_state_t          w_w_state_nxt;
  r_state_t          r_r_state;
  r_state_t          w_r_state_nxt;
  logic              r_awready;
  logic              r_wready;
  logic              r_bvalid;
  logic              r_arready;
  logic              r_rvalid;
  logic [DW-1:0]     r_rdata;
  logic [1:0]        r_awidx;
  logic [DW-1:0]     r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [3:0]        r_reg_wr;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_aw_capture;
  logic              w_w_capture;
  logic              w_commit;
  logic [1:0]        w_wr_idx;
  logic [DW-1:0]     w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;
  logic              w_unused;

  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID  & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write FSM next state and commit selection (live channel or held copy).
  always_comb begin
    w_w_state_nxt = r_w_state;
    w_aw_capture  = 1'b0;
    w_w_capture   = 1'b0;
    w_commit      = 1'b0;
    w_wr_idx      = r_awidx;
    w_wr_data     = r_wdata;
    w_wr_strb     = r_wstrb;
    case (r_w_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_w_state_nxt = W_RESP;
          w_commit      = 1'b1;
          w_wr_idx      = S_AXI_AWADDR[3:2];
          w_wr_data     = S_AXI_WDATA;
          w_wr_strb     = S_AXI_WSTRB;
        end else if (w_aw_hs) begin
          w_w_state_nxt = W_ADDR;
          w_aw_capture  = 1'b1;
        end else if (w_w_hs) begin
          w_w_state_nxt = W_DATA;
          w_w_capture   = 1'b1;
        end else begin
          w_w_state_nxt = W_IDLE;
        end
      end
      W_ADDR: begin
        if (w_w_hs) begin
          w_w_state_nxt = W_RESP;
          w_commit      = 1'b1;
          w_wr_data     = S_AXI_WDATA;
          w_wr_strb     = S_AXI_WSTRB;
        end else begin
          w_w_state_nxt = W_ADDR;
        end
      end
      W_DATA: begin
        if (w_aw_hs) begin
          w_w_state_nxt = W_RESP;
          w_commit      = 1'b1;
          w_wr_idx      = S_AXI_AWADDR[3:2];
        end else begin
          w_w_state_nxt = W_DATA;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_w_state_nxt = W_IDLE;
        else              w_w_state_nxt = W_RESP;
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  // Write FSM state, ready/valid decodes registered from the next state.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_awidx   <= 2'd0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_reg_wr  <= 4'b0000;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_awready <= (w_w_state_nxt == W_IDLE) || (w_w_state_nxt == W_DATA);
      r_wready  <= (w_w_state_nxt == W_IDLE) || (w_w_state_nxt == W_ADDR);
      r_bvalid  <= (w_w_state_nxt == W_RESP);
      r_reg_wr  <= w_commit ? (4'b0001 << w_wr_idx) : 4'b0000;
      if (w_aw_capture) r_awidx <= S_AXI_AWADDR[3:2];
      if (w_w_capture) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
    end
  end

  // Register file with per-lane strobe merge.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
    end else if (w_commit) begin
      r_reg[w_wr_idx] <= f_merge_lanes(r_reg[w_wr_idx], w_wr_data, w_wr_strb);
    end
  end

  // Read FSM next state.
  always_comb begin
    w_r_state_nxt = r_r_state;
    case (r_r_state)
      R_IDLE: begin
        if (w_ar_hs) w_r_state_nxt = R_DATA;
        else         w_r_state_nxt = R_IDLE;
      end
      R_DATA: begin
        if (S_AXI_RREADY) w_r_state_nxt = R_IDLE;
        else              w_r_state_nxt = R_DATA;
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // Read FSM state and data; RDATA samples the pre-write register value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_r_state <= w_r_state_nxt;
      r_arready <= (w_r_state_nxt == R_IDLE);
      r_rvalid  <= (w_r_state_nxt == R_DATA);
      if (w_ar_hs) r_rdata <= r_reg[S_AXI_ARADDR[3:2]];
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign reg0_o        = r_reg[0];
  assign reg1_o        = r_reg[1];
  assign reg2_o        = r_reg[2];
  assign reg3_o        = r_reg[3];
  assign reg_wr_o      = r_reg_wr;

endmodule

// File: tb/tb_rlc_axil_regs.sv
// Directed self-checking bench for rlc_axil_regs.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_rlc_axil_regs;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  reg_wr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rlc_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .S_AXI_ACLK(clk),        .S_AXI_ARESETN(rstn),
    .S_AXI_AWADDR(awaddr),   .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),     .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),     .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),   .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),     .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),
    .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3),
    .reg_wr_o(reg_wr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_ok, w_ok, b_ok, aw_now, w_now;
    int cyc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_ok = 1'b0; w_ok = 1'b0; cyc = 0;
    while (!(aw_ok && w_ok) && cyc < 20) begin
      @(negedge clk);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      tick();
      if (aw_now) begin awvalid = 1'b0; aw_ok = 1'b1; end
      if (w_now)  begin wvalid  = 1'b0; w_ok  = 1'b1; end
      cyc++;
    end
    if (!(aw_ok && w_ok)) chk("wr_addr_data_timeout", 32'd0, 32'd1);
    b_ok = 1'b0; cyc = 0;
    while (!b_ok && cyc < 20) begin
      @(negedge clk);
      if (bvalid) begin
        b_ok = 1'b1;
        chk("wr_b_latency", cyc, 32'd0);
        chk("wr_bresp", {30'd0, bresp}, 32'd0);
        chk("wr_pulse", {28'd0, reg_wr}, {28'd0, 4'b0001 << a[3:2]});
      end
      tick();
      cyc++;
    end
    if (!b_ok) chk("wr_b_timeout", 32'd0, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    bit ar_ok, r_ok, ar_now;
    int cyc;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    ar_ok = 1'b0; cyc = 0; d = 32'hxxxx_xxxx;
    while (!ar_ok && cyc < 20) begin
      @(negedge clk);
      ar_now = arvalid && arready;
      tick();
      if (ar_now) begin arvalid = 1'b0; ar_ok = 1'b1; end
      cyc++;
    end
    if (!ar_ok) chk("rd_ar_timeout", 32'd0, 32'd1);
    r_ok = 1'b0; cyc = 0;
    while (!r_ok && cyc < 20) begin
      @(negedge clk);
      if (rvalid) begin
        r_ok = 1'b1;
        d = rdata;
        chk("rd_latency", cyc, 32'd0);
        chk("rd_rresp", {30'd0, rresp}, 32'd0);
      end
      tick();
      cyc++;
    end
    if (!r_ok) chk("rd_r_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rstn = 1'b0; awaddr = 4'h0; awprot = 3'b000; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
    araddr = 4'h0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    chk("rst_reg_wr",  {28'd0, reg_wr}, 32'd0);
    chk("rst_regs",    reg0 | reg1 | reg2 | reg3, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    chk("rel_awready", {31'd0, awready}, 32'd1);
    chk("rel_wready",  {31'd0, wready},  32'd1);
    chk("rel_arready", {31'd0, arready}, 32'd1);
    tick();

    // Basic write then read-back of all four registers
    awprot = 3'b101; arprot = 3'b011;
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d);
      chk($sformatf("rdback_%0d", i), d, 32'(i + 1));
    end
    @(negedge clk);
    chk("reg0_o", reg0, 32'h1);
    chk("reg1_o", reg1, 32'h2);
    chk("reg2_o", reg2, 32'h3);
    chk("reg3_o", reg3, 32'h4);
    tick();

    // AW at cycle n, W at n+3, then BREADY held low for 5 cycles
    awaddr = 4'h8; awvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("late_w_awready_n", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("late_w_awready_n%0d", k), {31'd0, awready}, 32'd0);
      chk($sformatf("late_w_bvalid_n%0d", k),  {31'd0, bvalid},  32'd0);
      chk($sformatf("late_w_wready_n%0d", k),  {31'd0, wready},  32'd1);
      tick();
    end
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("late_w_awready_n3", {31'd0, awready}, 32'd0);
    chk("late_w_bvalid_n3",  {31'd0, bvalid},  32'd0);
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    chk("late_w_bvalid_n4", {31'd0, bvalid}, 32'd1);
    chk("late_w_pulse",     {28'd0, reg_wr}, 32'h4);
    chk("late_w_reg2",      reg2, 32'hDEADBEEF);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bhold_bvalid_%0d", k),  {31'd0, bvalid},  32'd1);
      chk($sformatf("bhold_awready_%0d", k), {31'd0, awready}, 32'd0);
      chk($sformatf("bhold_wready_%0d", k),  {31'd0, wready},  32'd0);
      chk($sformatf("bhold_pulse_%0d", k),   {28'd0, reg_wr},  32'd0);
      tick();
    end
    bready = 1'b1;
    @(negedge clk);
    chk("bhold_last_bvalid", {31'd0, bvalid}, 32'd1);
    tick();
    @(negedge clk);
    chk("bdone_bvalid",  {31'd0, bvalid},  32'd0);
    chk("bdone_awready", {31'd0, awready}, 32'd1);
    chk("bdone_wready",  {31'd0, wready},  32'd1);
    tick();

    // Read with RREADY held low for 5 cycles
    araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("rhold_arready_req", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rhold_rvalid_%0d", k),  {31'd0, rvalid},  32'd1);
      chk($sformatf("rhold_rdata_%0d", k),   rdata, 32'hDEADBEEF);
      chk($sformatf("rhold_arready_%0d", k), {31'd0, arready}, 32'd0);
      tick();
    end
    rready = 1'b1;
    @(negedge clk);
    chk("rhold_last_rvalid", {31'd0, rvalid}, 32'd1);
    tick();
    @(negedge clk);
    chk("rdone_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rdone_arready", {31'd0, arready}, 32'd1);
    tick();

    // Byte-lane strobes; low address bits ignored on the read
    axi_write(4'h4, 32'h11223344, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101);
    @(negedge clk);
    chk("strb_reg1", reg1, 32'h11BB33DD);
    tick();
    axi_read(4'h5, d);
    chk("strb_rdback", d, 32'h11BB33DD);

    // Same-edge read and write of register 3
    awaddr = 4'hC; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 4'hC; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("same_rdys", {29'd0, awready, wready, arready}, 32'h7);
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("same_rvalid", {31'd0, rvalid}, 32'd1);
    chk("same_rdata_old", rdata, 32'h4);
    chk("same_bvalid", {31'd0, bvalid}, 32'd1);
    chk("same_reg3", reg3, 32'h9);
    chk("same_pulse", {28'd0, reg_wr}, 32'h8);
    tick();
    rready = 1'b1;
    tick();
    axi_read(4'hC, d);
    chk("same_rdback_new", d, 32'h9);

    // Reset after AW-only handshake aborts the write
    awaddr = 4'h0; awvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk("abort_awready", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    chk("abort_pre_bvalid", {31'd0, bvalid}, 32'd0);
    tick();
    rstn = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("abort_bvalid", {31'd0, bvalid}, 32'd0);
    chk("abort_reg0", reg0, 32'd0);
    chk("abort_regs", reg1 | reg2 | reg3, 32'd0);
    chk("abort_awready_rst", {31'd0, awready}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_rel_rdys", {29'd0, awready, wready, arready}, 32'h7);
    chk("abort_rel_bvalid", {31'd0, bvalid}, 32'd0);
    tick();

    // W first, AW later: a stale AW must not complete this write
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", {31'd0, wready}, 32'd1);
    tick();
    wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("wfirst_bvalid_%0d", k),  {31'd0, bvalid},  32'd0);
      chk($sformatf("wfirst_awready_%0d", k), {31'd0, awready}, 32'd1);
      chk($sformatf("wfirst_wready_%0d", k),  {31'd0, wready},  32'd0);
      tick();
    end
    awaddr = 4'h0; awvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_aw_awready", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
    chk("wfirst_pulse", {28'd0, reg_wr}, 32'h1);
    chk("wfirst_reg0", reg0, 32'h55);
    tick();
    @(negedge clk);
    chk("wfirst_bdone", {31'd0, bvalid}, 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
